// File: rtl/seq_mult8_pkg.sv
// rtl/seq_mult8_pkg.sv - shared widths and state encoding for the sequential multiplier
package seq_mult8_pkg;

    localparam int WIDTH  = 8;
    localparam int PWIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_mult8_if.sv
// rtl/seq_mult8_if.sv - start/operand request and result handshake of the multiplier
interface seq_mult8_if;
    import seq_mult8_pkg::*;

    logic              start;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic              ready;
    logic              busy;
    logic              done;
    logic [PWIDTH-1:0] product;

    modport master (
        output start, a, b,
        input  ready, busy, done, product
    );

    modport slave (
        input  start, a, b,
        output ready, busy, done, product
    );

endinterface

// File: rtl/seq_mult8_adder.sv
// rtl/seq_mult8_adder.sv - 8-bit combinational ripple adder with carry in/out
module seq_mult8_adder
    import seq_mult8_pkg::*;
(
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/seq_mult8.sv
// rtl/seq_mult8.sv - 8x8 unsigned shift-and-add multiplier, one partial product per cycle
module seq_mult8
    import seq_mult8_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    seq_mult8_if.slave  bus
);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  mcand_q, mcand_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [PWIDTH-1:0] product_q, product_d;

    logic [WIDTH-1:0]  add_sum;
    logic              add_cout;
    logic [WIDTH:0]    cs;
    logic [WIDTH-1:0]  acc_next;
    logic [WIDTH-1:0]  q_next;

    seq_mult8_adder u_adder (
        .x    (acc_q),
        .y    (mcand_q),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Carry becomes the new acc MSB; the dropped sum LSB shifts into q.
    always_comb begin
        cs       = q_q[0] ? {add_cout, add_sum} : {1'b0, acc_q};
        acc_next = cs[WIDTH:1];
        q_next   = {cs[0], q_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        q_d       = q_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    mcand_d = bus.a;
                    q_d     = bus.b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                acc_d = acc_next;
                q_d   = q_next;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    product_d = {acc_next, q_next};
                    state_d   = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            acc_q     <= '0;
            q_q       <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign bus.ready   = (state_q == IDLE) || (state_q == DONE);
    assign bus.busy    = (state_q == RUN);
    assign bus.done    = (state_q == DONE);
    assign bus.product = product_q;

endmodule

// File: tb/tb_seq_mult8.sv
// tb/tb_seq_mult8.sv - self-checking bench for seq_mult8 against a cycle-phase model
module tb_seq_mult8;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    seq_mult8_if bus ();

    seq_mult8 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Model: phase 0 = waiting, 1..8 = the eight run cycles, 9 = result cycle.
    int      m_phase = 0;
    int      m_a = 0, m_b = 0;
    int      m_prod = 0;
    int      m_dones = 0;
    int      dut_dones = 0;
    bit      chk_en = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_phase = 0;
            m_prod  = 0;
        end else if ((m_phase == 0 || m_phase == 9) && bus.start) begin
            m_phase = 1;
            m_a     = int'(bus.a);
            m_b     = int'(bus.b);
        end else if (m_phase >= 1 && m_phase <= 7) begin
            m_phase = m_phase + 1;
        end else if (m_phase == 8) begin
            m_phase = 9;
            m_prod  = m_a * m_b;
            m_dones = m_dones + 1;
        end else begin
            m_phase = 0;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("ready",   int'(bus.ready), int'(m_phase == 0 || m_phase == 9));
            check("busy",    int'(bus.busy),  int'(m_phase >= 1 && m_phase <= 8));
            check("done",    int'(bus.done),  int'(m_phase == 9));
            check("product", int'(bus.product), m_prod);
            if (bus.done) dut_dones++;
        end
    end

    // Drives one operation; immediate=1 issues start in the current (result) cycle.
    task automatic run_op(input int av, input int bv, input bit immediate);
        int lat;
        if (!immediate) @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'(av);
        bus.b     = 8'(bv);
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = 8'($urandom_range(0, 255));
        bus.b     = 8'($urandom_range(0, 255));
        lat = 1;
        while (!bus.done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, 9);
        check("op_product", int'(bus.product), av * bv);
    endtask

    initial begin
        int d0;
        int busy_cnt;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(negedge clk);
        check("rst_ready",   int'(bus.ready), 1);
        check("rst_busy",    int'(bus.busy), 0);
        check("rst_done",    int'(bus.done), 0);
        check("rst_product", int'(bus.product), 0);
        chk_en = 1'b1;
        rst_n  = 1'b1;

        run_op(255, 255, 1'b0);
        check("lit_ff_ff", int'(bus.product), 'hFE01);
        run_op(13, 11, 1'b0);
        check("lit_13_11", int'(bus.product), 'h008F);
        run_op(0, 200, 1'b0);
        check("lit_0_200", int'(bus.product), 'h0000);
        run_op(1, 128, 1'b0);
        check("lit_1_128", int'(bus.product), 'h0080);

        // Back-to-back: second start lands in the result cycle of the first.
        run_op(2, 7, 1'b1);
        check("lit_b2b", int'(bus.product), 'h000E);

        // Start held through RUN with operands scrambled every cycle.
        @(negedge clk);
        @(negedge clk);
        d0 = dut_dones;
        busy_cnt = 0;
        bus.start = 1'b1;
        bus.a = 8'd3;
        bus.b = 8'd5;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            if (bus.busy) busy_cnt++;
            if (i < 9) begin
                bus.a = 8'($urandom_range(0, 255));
                bus.b = 8'($urandom_range(0, 255));
            end else begin
                bus.start = 1'b0;
            end
        end
        check("hold_done", int'(bus.done), 1);
        check("hold_product", int'(bus.product), 'h000F);
        check("hold_busy_cycles", busy_cnt, 8);
        repeat (3) @(negedge clk);
        check("hold_done_count", dut_dones - d0, 1);

        // Reset asserted during the fourth run cycle aborts the operation.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = 8'd200;
        bus.b = 8'd100;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        d0 = dut_dones;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_ready", int'(bus.ready), 1);
        check("abort_product", int'(bus.product), 0);
        repeat (12) @(negedge clk);
        check("abort_no_done", dut_dones - d0, 0);
        run_op(9, 7, 1'b0);
        check("lit_after_abort", int'(bus.product), 'h003F);

        // Corners and random operands, idle-separated then chained back-to-back.
        run_op(255, 0, 1'b0);
        run_op(128, 2, 1'b0);
        run_op(255, 1, 1'b0);
        for (int i = 0; i < 250; i++)
            run_op($urandom_range(0, 255), $urandom_range(0, 255), 1'b0);
        for (int i = 0; i < 150; i++)
            run_op($urandom_range(0, 255), $urandom_range(0, 255), 1'b1);

        repeat (3) @(negedge clk);
        check("done_pulse_total", dut_dones, m_dones);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
